ide_mgmt_bridge: RTL and testbench
==================================

Name: ide_mgmt_bridge

Overview:
Host-side sequencer for the IDE management port of the Gayle/IDE subsystem. It watches the per-port `ide_req` lines and latches request events into pending flags. On host command it runs bursts of reads or writes on the management bus (`ide_address` / `ide_read` / `ide_write`). Data is buffered in a small word FIFO so the host (HPS/ARM link) can stream taskfile contents and sector data at its own pace.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW words (8).
TIMEOUT_CYCLES, 24'd1000000, watchdog limit (only with IDE_BRIDGE_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all logic rising edge
rst_n  input  1  asynchronous active-low reset
ide_req  input  6  [2:0] port0 request code, [5:3] port1 request code
ide_address  output  5  [4] port select, [3:0] register within port
ide_write  output  1  one-cycle management write strobe
ide_writedata  output  16  management write data
ide_read  output  1  one-cycle management read strobe
ide_readdata  input  16  management read data, valid the cycle after ide_read
hst_start  input  1  one-cycle burst start
hst_dir  input  1  1=write to IDE, 0=read from IDE
hst_port  input  1  target port
hst_reg  input  4  first register address
hst_inc  input  1  1=increment register per word (taskfile), 0=fixed (data reg)
hst_count  input  9  word count, 0 means 512
hst_push  input  1  push hst_wdata into FIFO (write bursts)
hst_wdata  input  16  host write word
hst_pop  input  1  pop FIFO head (read bursts)
hst_rdata  output  16  FIFO head word, valid when hst_rvalid
hst_rvalid  output  1  FIFO non-empty during read burst
hst_wready  output  1  FIFO not full during write burst
hst_busy  output  1  burst in progress
hst_done  output  1  one-cycle pulse at burst end
hst_err  output  1  sticky burst-abort flag, cleared by hst_start
req_pending  output  2  per-port latched request flag
req_ack  input  2  per-bit clear of req_pending
host_irq  output  1  OR of req_pending

Behaviour:
- Reset, asynchronous on `rst_n` low:
  - FSM to IDLE; FIFO emptied.
  - All strobes 0; `ide_address`=0, `ide_writedata`=0.
  - `req_pending`=0, `hst_err`=0, `hst_busy`=0, `hst_done`=0.
- Request latch:
  - For each port, `req_pending[p]` sets on any cycle where the port's 3-bit `ide_req` differs from its value in the previous cycle and the new value is nonzero.
  - `req_ack[p]` clears the bit; a simultaneous set wins.
- `hst_start` is ignored while `hst_busy`. When accepted it:
  - latches port, register, direction, increment mode and count (0 is stored as 512);
  - clears the FIFO and `hst_err`;
  - raises `hst_busy` the next cycle.
- FSM states: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, FINISH.
  - IDLE→RD_ISSUE or WR_ISSUE on an accepted start.
  - RD_ISSUE: waits while FIFO full or count=0. Otherwise pulses `ide_read` with `ide_address={port,reg}`, then goes to RD_CAPT.
  - RD_CAPT: pushes `ide_readdata` into the FIFO and decrements count. Register increments if `hst_inc` (4-bit wrap, 15→0). Returns to RD_ISSUE if count≠0, else FINISH.
  - WR_ISSUE: if FIFO non-empty, pops the head, drives `ide_writedata` and pulses `ide_write` in the same cycle, decrements count and increments the register as above. Goes to FINISH when count reaches 0. Throughput is 1 word/cycle.
  - FINISH: pulses `hst_done` for one cycle, drops `hst_busy`, returns to IDLE.
- Read latency: 2 cycles per word minimum.
- End of read burst: the burst ends when the last word enters the FIFO. The host drains the rest after `hst_done`; `hst_rvalid` remains valid until the FIFO is empty.
- FIFO rules:
  - Push when full is dropped.
  - Pop when empty is ignored.
  - Simultaneous push and pop on a full or empty FIFO are both honoured where legal; occupancy stays consistent.
  - Host push during a read burst, or pop during a write burst, is ignored.
- Strobes are never asserted outside RD_ISSUE / WR_ISSUE. Management read and write are mutually exclusive.

Optional Feature:
IDE_BRIDGE_TIMEOUT_EN.
- Defined: a 24-bit watchdog counts cycles in which the FSM is stalled, i.e. FIFO full in RD_ISSUE or empty in WR_ISSUE. Any progress resets it.
- On reaching TIMEOUT_CYCLES: `hst_err` sets, the remaining count is discarded, and the FSM goes to FINISH, so `hst_done` still pulses.
- Undefined: no watchdog; bursts stall indefinitely and `hst_err` is tied 0.

Test Plan:
- Reset: assert `rst_n`=0 mid-burst → strobes drop immediately, FIFO empty, `hst_busy`=0, `req_pending`=0.
- Taskfile read: port1, reg 1, inc=1, count 7, readdata echoes address → `ide_address` 0x11..0x17; host pops 0x11..0x17; one `hst_done`.
- Sector write: port0, reg 0, inc=0, count 0; host pushes 512 words at 1 word/cycle → 512 `ide_write` pulses, all at address 0x00, data in order.
- Backpressure: 16-word read, host never pops → exactly 8 `ide_read` pulses, then stall. Popping resumes reads, all 16 words arrive, no loss.
- Request: `ide_req[5:3]` goes 0→3 → `req_pending`=2'b10 and `host_irq`=1. `req_ack`=2'b10 → cleared. A repeated value 3 does not re-set the flag.
- With IDE_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=100: write burst of 4, push 1 word → `hst_err`=1, `hst_done` ~100 cycles after the first write, next burst accepted normally.

Source files
------------

// File: rtl/ide_mgmt_bridge_if.sv
// Bundle of the IDE management bus and host streaming port of the bridge.
// master = bridge side, slave = host/IDE environment side.
interface ide_mgmt_bridge_if;
    logic [5:0]  ide_req;
    logic [4:0]  ide_address;
    logic        ide_write;
    logic [15:0] ide_writedata;
    logic        ide_read;
    logic [15:0] ide_readdata;
    logic        hst_start;
    logic        hst_dir;
    logic        hst_port;
    logic [3:0]  hst_reg;
    logic        hst_inc;
    logic [8:0]  hst_count;
    logic        hst_push;
    logic [15:0] hst_wdata;
    logic        hst_pop;
    logic [15:0] hst_rdata;
    logic        hst_rvalid;
    logic        hst_wready;
    logic        hst_busy;
    logic        hst_done;
    logic        hst_err;
    logic [1:0]  req_pending;
    logic [1:0]  req_ack;
    logic        host_irq;

    modport master (
        input  ide_req, ide_readdata, hst_start, hst_dir, hst_port, hst_reg, hst_inc,
               hst_count, hst_push, hst_wdata, hst_pop, req_ack,
        output ide_address, ide_write, ide_writedata, ide_read, hst_rdata, hst_rvalid,
               hst_wready, hst_busy, hst_done, hst_err, req_pending, host_irq
    );

    modport slave (
        output ide_req, ide_readdata, hst_start, hst_dir, hst_port, hst_reg, hst_inc,
               hst_count, hst_push, hst_wdata, hst_pop, req_ack,
        input  ide_address, ide_write, ide_writedata, ide_read, hst_rdata, hst_rvalid,
               hst_wready, hst_busy, hst_done, hst_err, req_pending, host_irq
    );
endinterface

// File: rtl/ide_mgmt_bridge.sv
// ide_bridge_fifo: generic synchronous word FIFO with flush, show-ahead head word.
// Latency: push visible at head the cycle after; pop takes effect at the clock edge.
// Backpressure: push when full is dropped unless a pop frees the slot that cycle; pop when empty ignored.
module ide_bridge_fifo #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_vld,
    output logic [DW-1:0] head_dat,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          do_push;
    logic          do_pop;

    assign empty    = (occ == '0);
    assign full     = (occ == (AW+1)'(DEPTH));
    assign do_pop   = pop_vld && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_dat;
    end
endmodule

// ide_mgmt_bridge: host-side burst sequencer for the IDE management bus with word FIFO and request latch.
// Latency: reads 2 cycles/word (strobe then capture), writes 1 word/cycle; hst_busy rises the cycle after start.
// Backpressure: reads stall while FIFO full, writes while empty; `define IDE_BRIDGE_TIMEOUT_EN adds a stall watchdog.
module ide_mgmt_bridge #(
    parameter int          FIFO_AW        = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ide_mgmt_bridge_if.master     bus
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, FINISH} state_t;

    state_t      state_q, state_d;
    logic        port_q, dir_q, inc_q;
    logic [3:0]  reg_q, reg_d, reg_step;
    logic [9:0]  cnt_q, cnt_d;
    logic        start_acc;
    logic        rd_stb, wr_stb;
    logic        eng_push, eng_pop;
    logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [15:0] fifo_push_dat, fifo_head;
    logic        timeout_hit;
    logic [5:0]  req_prev;
    logic [1:0]  req_pend, req_set;

    assign start_acc = bus.hst_start && (state_q == IDLE);
    assign reg_step  = inc_q ? reg_q + 4'd1 : reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            dir_q   <= 1'b0;
            inc_q   <= 1'b0;
            reg_q   <= 4'd0;
            cnt_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            if (start_acc) begin
                port_q <= bus.hst_port;
                dir_q  <= bus.hst_dir;
                inc_q  <= bus.hst_inc;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        reg_d    = reg_q;
        cnt_d    = cnt_q;
        rd_stb   = 1'b0;
        wr_stb   = 1'b0;
        eng_push = 1'b0;
        eng_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    reg_d   = bus.hst_reg;
                    cnt_d   = (bus.hst_count == 9'd0) ? 10'd512 : {1'b0, bus.hst_count};
                    state_d = bus.hst_dir ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (timeout_hit) begin
                    cnt_d   = 10'd0;
                    state_d = FINISH;
                end else if (!fifo_full && cnt_q != 10'd0) begin
                    rd_stb  = 1'b1;
                    state_d = RD_CAPT;
                end
            end
            RD_CAPT: begin
                eng_push = 1'b1;
                cnt_d    = cnt_q - 10'd1;
                reg_d    = reg_step;
                state_d  = (cnt_q == 10'd1) ? FINISH : RD_ISSUE;
            end
            WR_ISSUE: begin
                if (timeout_hit) begin
                    cnt_d   = 10'd0;
                    state_d = FINISH;
                end else if (!fifo_empty) begin
                    eng_pop = 1'b1;
                    wr_stb  = 1'b1;
                    cnt_d   = cnt_q - 10'd1;
                    reg_d   = reg_step;
                    if (cnt_q == 10'd1) state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The FIFO direction follows the burst: engine fills it on reads, host fills it on writes.
    assign fifo_push     = eng_push || (bus.hst_push && dir_q && state_q == WR_ISSUE);
    assign fifo_pop      = eng_pop || (bus.hst_pop && !dir_q);
    assign fifo_push_dat = dir_q ? bus.hst_wdata : bus.ide_readdata;

    ide_bridge_fifo #(.AW(FIFO_AW), .DW(16)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc),
        .push_vld (fifo_push),
        .push_dat (fifo_push_dat),
        .pop_vld  (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.ide_read      = rd_stb;
    assign bus.ide_write     = wr_stb;
    assign bus.ide_address   = {port_q, reg_q};
    assign bus.ide_writedata = wr_stb ? fifo_head : 16'd0;
    assign bus.hst_rdata     = fifo_head;
    assign bus.hst_rvalid    = !dir_q && !fifo_empty;
    assign bus.hst_wready    = (state_q == WR_ISSUE) && !fifo_full;
    assign bus.hst_busy      = (state_q != IDLE);
    assign bus.hst_done      = (state_q == FINISH);

`ifdef IDE_BRIDGE_TIMEOUT_EN
    logic [23:0] wd_q;
    logic        err_q;
    logic        stalled;

    assign stalled     = (state_q == RD_ISSUE && fifo_full) || (state_q == WR_ISSUE && fifo_empty);
    assign timeout_hit = stalled && (wd_q >= TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= 24'd0;
            err_q <= 1'b0;
        end else begin
            if (start_acc)        err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
            if (!stalled || timeout_hit) wd_q <= 24'd0;
            else                         wd_q <= wd_q + 24'd1;
        end
    end

    assign bus.hst_err = err_q;
`else
    logic [23:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign bus.hst_err        = 1'b0;
`endif

    // A request event is a change of a port's code to a nonzero value.
    assign req_set[0] = (bus.ide_req[2:0] != req_prev[2:0]) && (bus.ide_req[2:0] != 3'd0);
    assign req_set[1] = (bus.ide_req[5:3] != req_prev[5:3]) && (bus.ide_req[5:3] != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev <= 6'd0;
            req_pend <= 2'd0;
        end else begin
            req_prev <= bus.ide_req;
            req_pend <= (req_pend & ~bus.req_ack) | req_set;
        end
    end

    assign bus.req_pending = req_pend;
    assign bus.host_irq    = |req_pend;
endmodule

// File: tb/tb_ide_mgmt_bridge.sv
// Scoreboard bench for ide_mgmt_bridge: stimulus pushes expected strobes/words, a negedge monitor pops and compares.
module tb_ide_mgmt_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ide_mgmt_bridge_if bus ();
    ide_mgmt_bridge #(.FIFO_AW(3), .TIMEOUT_CYCLES(24'd100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int n_reads = 0;
    int n_writes = 0;
    int n_done = 0;
    logic [4:0]  exp_rd_addr_q[$];
    logic [20:0] exp_wr_q[$];
    logic [15:0] exp_pop_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] addr_of(input logic port, input logic [3:0] rg, input logic inc, input int k);
        int r;
        r = inc ? (int'(rg) + k) % 16 : int'(rg);
        return {port, r[3:0]};
    endfunction

    // IDE register file model: read data = {word index within burst, address}.
    initial begin
        logic [10:0] serial;
        serial = 11'd0;
        forever begin
            @(negedge clk);
            if (bus.hst_start && !bus.hst_busy) serial = 11'd0;
            if (bus.ide_read) begin
                bus.ide_readdata = {serial, bus.ide_address};
                serial = serial + 11'd1;
            end
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ide_read || bus.ide_write)
                chk("rw_exclusive", 32'(bus.ide_read & bus.ide_write), 32'd0);
            if (bus.ide_read) begin
                n_reads++;
                chk("rd_expected", 32'(exp_rd_addr_q.size() > 0), 32'd1);
                if (exp_rd_addr_q.size() > 0) chk("rd_addr", 32'(bus.ide_address), 32'(exp_rd_addr_q.pop_front()));
            end
            if (bus.ide_write) begin
                n_writes++;
                chk("wr_expected", 32'(exp_wr_q.size() > 0), 32'd1);
                if (exp_wr_q.size() > 0) chk("wr_addr_data", 32'({bus.ide_address, bus.ide_writedata}), 32'(exp_wr_q.pop_front()));
            end
            if (bus.hst_pop && bus.hst_rvalid) begin
                chk("pop_expected", 32'(exp_pop_q.size() > 0), 32'd1);
                if (exp_pop_q.size() > 0) chk("pop_data", 32'(bus.hst_rdata), 32'(exp_pop_q.pop_front()));
            end
            if (bus.hst_done) n_done++;
        end
    end

    task automatic issue_start(input logic dir, input logic port, input logic [3:0] rg, input logic inc, input logic [8:0] cnt);
        bus.hst_start = 1'b1;
        bus.hst_dir   = dir;
        bus.hst_port  = port;
        bus.hst_reg   = rg;
        bus.hst_inc   = inc;
        bus.hst_count = cnt;
        tick();
        bus.hst_start = 1'b0;
    endtask

    task automatic run_read(input logic port, input logic [3:0] rg, input logic inc, input logic [8:0] cnt,
                            input int pop_pct, input int hold);
        int n, r0, d0, cyc;
        logic fin;
        n = (cnt == 9'd0) ? 512 : int'(cnt);
        for (int k = 0; k < n; k++) begin
            exp_rd_addr_q.push_back(addr_of(port, rg, inc, k));
            exp_pop_q.push_back({k[10:0], addr_of(port, rg, inc, k)});
        end
        r0 = n_reads;
        d0 = n_done;
        issue_start(1'b0, port, rg, inc, cnt);
        if (hold > 0) begin
            repeat (hold) tick();
            chk("bp_read_strobes", n_reads - r0, 8);
            chk("bp_busy", 32'(bus.hst_busy), 32'd1);
            chk("bp_rvalid", 32'(bus.hst_rvalid), 32'd1);
        end
        fin = 1'b0;
        for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
            bus.hst_pop   = bus.hst_rvalid && ($urandom_range(99) < pop_pct);
            bus.hst_push  = 1'($urandom_range(1));
            bus.hst_wdata = 16'($urandom);
            if (cyc == 2 && bus.hst_busy) begin
                bus.hst_start = 1'b1;
                bus.hst_dir   = 1'b1;
                bus.hst_count = 9'd3;
            end else begin
                bus.hst_start = 1'b0;
            end
            tick();
            fin = !bus.hst_busy && !bus.hst_rvalid;
        end
        bus.hst_pop = 1'b0;
        bus.hst_push = 1'b0;
        bus.hst_start = 1'b0;
        chk("rd_finished", 32'(fin), 32'd1);
        chk("rd_strobes", n_reads - r0, n);
        chk("rd_words_left", exp_pop_q.size(), 0);
        chk("rd_done_pulses", n_done - d0, 1);
        chk("rd_err", 32'(bus.hst_err), 32'd0);
        exp_rd_addr_q.delete();
        exp_pop_q.delete();
    endtask

    task automatic run_write(input logic port, input logic [3:0] rg, input logic inc, input logic [8:0] cnt,
                             input int push_pct, output int cyc);
        int n, w0, d0, pushed;
        logic fin;
        logic [4:0] aq[$];
        n = (cnt == 9'd0) ? 512 : int'(cnt);
        for (int k = 0; k < n; k++) aq.push_back(addr_of(port, rg, inc, k));
        w0 = n_writes;
        d0 = n_done;
        pushed = 0;
        issue_start(1'b1, port, rg, inc, cnt);
        fin = 1'b0;
        for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
            bus.hst_push = 1'b0;
            if (bus.hst_wready && pushed < n && $urandom_range(99) < push_pct) begin
                bus.hst_push  = 1'b1;
                bus.hst_wdata = 16'($urandom);
                exp_wr_q.push_back({aq.pop_front(), bus.hst_wdata});
                pushed++;
            end
            bus.hst_pop = 1'($urandom_range(1));
            if (cyc == 2 && bus.hst_busy) begin
                bus.hst_start = 1'b1;
                bus.hst_dir   = 1'b0;
                bus.hst_count = 9'd5;
            end else begin
                bus.hst_start = 1'b0;
            end
            tick();
            fin = !bus.hst_busy;
        end
        bus.hst_push = 1'b0;
        bus.hst_pop = 1'b0;
        bus.hst_start = 1'b0;
        chk("wr_finished", 32'(fin), 32'd1);
        chk("wr_strobes", n_writes - w0, n);
        chk("wr_words_left", exp_wr_q.size(), 0);
        chk("wr_done_pulses", n_done - d0, 1);
        chk("wr_err", 32'(bus.hst_err), 32'd0);
        exp_wr_q.delete();
    endtask

    initial begin
        logic [5:0] r;
        logic [1:0] a, mpend, mset;
        logic [5:0] mprev;
        int cyc;

        bus.ide_req = 6'd0;      bus.ide_readdata = 16'd0;
        bus.hst_start = 1'b0;    bus.hst_dir = 1'b0;   bus.hst_port = 1'b0;
        bus.hst_reg = 4'd0;      bus.hst_inc = 1'b0;   bus.hst_count = 9'd0;
        bus.hst_push = 1'b0;     bus.hst_wdata = 16'd0; bus.hst_pop = 1'b0;
        bus.req_ack = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.hst_busy), 32'd0);
        chk("rst_done", 32'(bus.hst_done), 32'd0);
        chk("rst_err", 32'(bus.hst_err), 32'd0);
        chk("rst_strobes", 32'({bus.ide_read, bus.ide_write}), 32'd0);
        chk("rst_addr_wdata", 32'({bus.ide_address, bus.ide_writedata}), 32'd0);
        chk("rst_pending", 32'({bus.req_pending, bus.host_irq}), 32'd0);
        chk("rst_rvalid_wready", 32'({bus.hst_rvalid, bus.hst_wready}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Request latch, directed.
        bus.ide_req = 6'b011_000; tick();
        chk("req_set_port1", 32'(bus.req_pending), 32'd2);
        chk("req_irq", 32'(bus.host_irq), 32'd1);
        bus.req_ack = 2'b10; tick(); bus.req_ack = 2'b00;
        chk("req_ack_clear", 32'(bus.req_pending), 32'd0);
        tick();
        chk("req_repeat_no_set", 32'({bus.req_pending, bus.host_irq}), 32'd0);
        bus.ide_req = 6'b011_101; bus.req_ack = 2'b01; tick();
        chk("req_set_beats_ack", 32'(bus.req_pending), 32'd1);
        bus.ide_req = 6'b011_000; tick();
        chk("req_zero_no_set", 32'(bus.req_pending), 32'd0);
        bus.ide_req = 6'd0; bus.req_ack = 2'b00; tick();

        // Request latch, randomized against an event model.
        mprev = 6'd0;
        mpend = 2'd0;
        for (int i = 0; i < 40; i++) begin
            r = {3'($urandom_range(2)), 3'($urandom_range(2))};
            a = 2'($urandom_range(3));
            bus.ide_req = r;
            bus.req_ack = a;
            tick();
            for (int p = 0; p < 2; p++) begin
                mset[p] = 1'b0;
                if (r[3*p +: 3] != mprev[3*p +: 3] && r[3*p +: 3] != 3'd0) mset[p] = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (mset[p]) mpend[p] = 1'b1;
                else if (a[p]) mpend[p] = 1'b0;
            end
            mprev = r;
            chk("req_rand_pending", 32'(bus.req_pending), 32'(mpend));
            chk("req_rand_irq", 32'(bus.host_irq), 32'(mpend != 2'd0));
        end
        bus.ide_req = 6'd0;
        bus.req_ack = 2'b11; tick(); bus.req_ack = 2'b00;

        // Taskfile read, sector write, backpressure.
        run_read(1'b1, 4'd1, 1'b1, 9'd7, 60, 0);
        run_write(1'b0, 4'd0, 1'b0, 9'd0, 100, cyc);
        chk("wr_throughput", 32'(cyc <= 520), 32'd1);
        run_read(1'b0, 4'd2, 1'b0, 9'd16, 50, 40);

        // Register wrap and random bursts.
        run_read(1'b0, 4'd14, 1'b1, 9'd5, 40, 0);
        run_write(1'b1, 4'd13, 1'b1, 9'd6, 50, cyc);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(1) == 1)
                run_write(1'($urandom), 4'($urandom), 1'($urandom), 9'($urandom_range(20, 1)), $urandom_range(90, 30), cyc);
            else
                run_read(1'($urandom), 4'($urandom), 1'($urandom), 9'($urandom_range(20, 1)), $urandom_range(90, 30), 0);
        end

`ifdef IDE_BRIDGE_TIMEOUT_EN
        begin : timeout_case
            int w0, d0, tc;
            logic tfin;
            w0 = n_writes;
            d0 = n_done;
            issue_start(1'b1, 1'b0, 4'd2, 1'b1, 9'd4);
            bus.hst_push = 1'b1;
            bus.hst_wdata = 16'hBEEF;
            exp_wr_q.push_back({addr_of(1'b0, 4'd2, 1'b1, 0), 16'hBEEF});
            tick();
            bus.hst_push = 1'b0;
            tfin = 1'b0;
            for (tc = 0; tc < 400 && !tfin; tc++) begin
                tick();
                tfin = !bus.hst_busy;
            end
            chk("tmo_finished", 32'(tfin), 32'd1);
            chk("tmo_err", 32'(bus.hst_err), 32'd1);
            chk("tmo_writes", n_writes - w0, 1);
            chk("tmo_done", n_done - d0, 1);
            chk("tmo_latency", 32'(tc >= 95 && tc <= 110), 32'd1);
            exp_wr_q.delete();
            run_write(1'b1, 4'd3, 1'b0, 9'd3, 80, cyc);
        end
`endif

        // Asynchronous reset in the middle of a read burst.
        bus.ide_req = 6'b010_000; tick(); bus.ide_req = 6'd0;
        for (int k = 0; k < 16; k++) exp_rd_addr_q.push_back(addr_of(1'b1, 4'd0, 1'b0, k));
        issue_start(1'b0, 1'b1, 4'd0, 1'b0, 9'd16);
        repeat (3) tick();
        for (int i = 0; i < 10 && !bus.ide_read; i++) tick();
        chk("mid_burst_read_seen", 32'(bus.ide_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_strobes", 32'({bus.ide_read, bus.ide_write}), 32'd0);
        chk("arst_busy", 32'(bus.hst_busy), 32'd0);
        chk("arst_rvalid", 32'(bus.hst_rvalid), 32'd0);
        chk("arst_pending", 32'({bus.req_pending, bus.host_irq}), 32'd0);
        exp_rd_addr_q.delete();
        exp_pop_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_write(1'b1, 4'd2, 1'b1, 9'd3, 80, cyc);
        run_read(1'b1, 4'd9, 1'b1, 9'd9, 70, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
